btb_fetch_pc: RTL and testbench
===============================

# btb_fetch_pc

Fetch-side PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It produces the fetch PC and the predicted next PC (`pred_PC`) that travel down the pipeline with each instruction. It consumes the resolution result from the branch checker (`next_PC`, `br_taken_cancel`) to redirect fetch and train the BTB. It sits at the front of the IF stage and drives the instruction memory address.

## Interface
- `BTB_ENTRIES`, 16: number of BTB entries; must be a power of two and ≥2. IDX = log2(BTB_ENTRIES).
- `RESET_PC`, 32'h1c00_0000: first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `fetch_allow`  in  1  IF stage may advance this cycle. When 0, the PC is held.
- `fetch_PC`  out  32  current fetch address.
- `fetch_valid`  out  1  `fetch_PC` is a real fetch request.
- `pred_PC`  out  32  predicted next PC for the instruction at `fetch_PC`.
- `resolve_valid`  in  1  a resolution record is presented this cycle.
- `resolve_is_branch`  in  1  the resolved instruction is jirl/b/beq/bne/bl.
- `resolve_inst_PC`  in  32  PC of the resolved instruction.
- `resolve_taken`  in  1  true outcome: next_PC ≠ inst_PC+4.
- `next_PC`  in  32  correct next PC from the branch checker.
- `br_taken_cancel`  in  1  misprediction; redirect fetch to `next_PC`.
- `mispred_cnt`  out  32  count of redirects since reset.

## Operation
- Entry fields: `valid`, `tag[31:IDX+2]`, `target[31:0]`, `ctr[1:0]`.
- Lookup (combinational on `fetch_PC`):
  - index = `fetch_PC[IDX+1:2]`.
  - hit = `valid` && tag equals `fetch_PC[31:IDX+2]`.
  - `pred_PC` = `target` if hit && `ctr[1]`; otherwise `fetch_PC+4` (mod 2^32, wraps at 32'hffff_fffc → 0).
- PC update, in priority order:
  - reset → `RESET_PC`.
  - `br_taken_cancel` → `next_PC`. This applies regardless of `fetch_allow`.
  - `fetch_allow` → `pred_PC`.
  - otherwise hold.
- `fetch_valid`:
  - 0 during reset and in the cycle immediately after a cancel.
  - 1 otherwise.
- Training applies only when `resolve_valid && resolve_is_branch`. Index and tag are taken from `resolve_inst_PC`; "match" means the entry is valid and the tag is equal.
  - taken, match: `target` ← `next_PC`; `ctr` increments, saturating at 2'b11.
  - taken, no match: allocate or overwrite the entry; `valid`=1, tag written, `target` ← `next_PC`, `ctr` ← 2'b10.
  - not taken, match: `ctr` decrements, saturating at 2'b00; the entry stays valid.
  - not taken, no match: no change; never allocate on not-taken.
- When `resolve_valid` is 0, or `resolve_is_branch` is 0, the table is unchanged.
- `mispred_cnt` increments by 1 on every cycle with `br_taken_cancel`=1 and wraps at 2^32.
- Reset clears all `valid` bits and `ctr` fields to 0, and clears `mispred_cnt`. `tag` and `target` are don't-care.

## Timing
- Reset values:
  - `fetch_PC` = `RESET_PC`.
  - `fetch_valid` = 0.
  - `pred_PC` = `RESET_PC+4`, since every entry is invalid.
  - `mispred_cnt` = 0.
- The first valid fetch occurs in the first cycle after `reset` deasserts.
- `pred_PC` has zero-cycle (combinational) latency from `fetch_PC`.
- A redirect takes 1 cycle: `fetch_PC` = `next_PC` in the cycle after the cancel, with `fetch_valid`=0 for that one cycle. From the following cycle onward, fetch proceeds normally.
- BTB writes take effect at the clock edge. A lookup in the same cycle as a write to the same index sees the old contents; the new contents are visible from the next cycle.
- `br_taken_cancel` and `resolve_valid` may be asserted together, and both actions occur in that cycle.
- If `br_taken_cancel` is asserted without `resolve_valid`, only the redirect occurs.
- Reset asserted mid-operation overrides cancel, training, and stall in that same cycle.
- `br_taken_cancel` is honored only when `reset`=0.

## Test plan
- Reset, then hold `fetch_allow`=1 for 4 cycles → `fetch_PC` = 1c000000, 1c000004, 1c000008, 1c00000c; `pred_PC` = `fetch_PC+4`; `mispred_cnt`=0.
- Stall: `fetch_allow`=0 for 3 cycles at 1c000008 → `fetch_PC` holds 1c000008; `fetch_valid` stays 1.
- Branch learning:
  - Step 1: resolve inst_PC=1c000010, taken, next_PC=1c000100, with cancel → next cycle `fetch_PC`=1c000100, `fetch_valid`=0, `mispred_cnt`=1.
  - Step 2: the next fetch of 1c000010 gives `pred_PC`=1c000100.
- Counter demotion, starting from the learned entry (ctr=10):
  - Step 1: resolve not-taken at 1c000010 → ctr=01.
  - Step 2: the next fetch of 1c000010 gives `pred_PC`=1c000014.
- Alias: with 1c000010 learned, fetch 1c000050 (same index, different tag) → `pred_PC`=1c000054. A not-taken resolve at 1c000050 leaves the 1c000010 entry intact.
- Simultaneous events:
  - Case 1: cancel with next_PC=1c000200 while `fetch_allow`=0 → `fetch_PC`=1c000200 next cycle.
  - Case 2: `reset` with cancel → `fetch_PC`=1c000000 and `mispred_cnt`=0.

Source files
------------

// File: rtl/btb_fetch_pc.sv
// rtl/btb_fetch_pc.sv - fetch PC generator with direct-mapped BTB and 2-bit direction counters
module btb_fetch_pc #(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h1c00_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_fetch_allow,
  output logic [31:0] o_fetch_pc,
  output logic        o_fetch_valid,
  output logic [31:0] o_pred_pc,
  input  logic        i_resolve_valid,
  input  logic        i_resolve_is_branch,
  input  logic [31:0] i_resolve_inst_pc,
  input  logic        i_resolve_taken,
  input  logic [31:0] i_next_pc,
  input  logic        i_br_taken_cancel,
  output logic [31:0] o_mispred_cnt
);

  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = 30 - IDX;

  logic [BTB_ENTRIES-1:0] r_valid;
  logic [TW-1:0]          r_tag    [BTB_ENTRIES];
  logic [31:0]            r_target [BTB_ENTRIES];
  logic [1:0]             r_ctr    [BTB_ENTRIES];

  logic [31:0] r_pc;
  logic [31:0] r_mispred_cnt;
  logic        r_redirect;

  logic [IDX-1:0] w_lk_idx;
  logic           w_lk_hit;
  logic [31:0]    w_pred_pc;
  logic [IDX-1:0] w_tr_idx;
  logic [TW-1:0]  w_tr_tag;
  logic           w_tr_match;
  logic           w_train;

  // Lookup is purely combinational on the current fetch PC.
  assign w_lk_idx  = r_pc[IDX+1:2];
  assign w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == r_pc[31:IDX+2]);
  assign w_pred_pc = (w_lk_hit && r_ctr[w_lk_idx][1]) ? r_target[w_lk_idx] : r_pc + 32'd4;

  assign w_tr_idx   = i_resolve_inst_pc[IDX+1:2];
  assign w_tr_tag   = i_resolve_inst_pc[31:IDX+2];
  assign w_tr_match = r_valid[w_tr_idx] && (r_tag[w_tr_idx] == w_tr_tag);
  assign w_train    = i_resolve_valid && i_resolve_is_branch;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_redirect    <= 1'b0;
      r_mispred_cnt <= 32'd0;
    end else if (i_br_taken_cancel) begin
      r_pc          <= i_next_pc;
      r_redirect    <= 1'b1;
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end else begin
      r_redirect <= 1'b0;
      if (i_fetch_allow) begin
        r_pc <= w_pred_pc;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_ctr[i] <= 2'b00;
      end
    end else if (w_train) begin
      if (i_resolve_taken) begin
        r_valid[w_tr_idx] <= 1'b1;
        if (!w_tr_match) begin
          r_ctr[w_tr_idx] <= 2'b10;
        end else if (r_ctr[w_tr_idx] != 2'b11) begin
          r_ctr[w_tr_idx] <= r_ctr[w_tr_idx] + 2'd1;
        end
      end else if (w_tr_match && r_ctr[w_tr_idx] != 2'b00) begin
        r_ctr[w_tr_idx] <= r_ctr[w_tr_idx] - 2'd1;
      end
    end
  end

  // Tag and target need no reset: an entry is only consulted once its valid bit is set.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_train && i_resolve_taken) begin
      r_tag[w_tr_idx]    <= w_tr_tag;
      r_target[w_tr_idx] <= i_next_pc;
    end
  end

  assign o_fetch_pc    = r_pc;
  assign o_fetch_valid = !i_reset && !r_redirect;
  assign o_pred_pc     = w_pred_pc;
  assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_btb_fetch_pc.sv
// tb/tb_btb_fetch_pc.sv - directed vector table plus randomized run against a behavioural model
module tb_btb_fetch_pc;

  localparam int          N  = 16;
  localparam logic [31:0] RP = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset, fetch_allow, resolve_valid, resolve_is_branch, resolve_taken, br_taken_cancel;
  logic [31:0] resolve_inst_pc, next_pc;
  logic [31:0] fetch_pc, pred_pc, mispred_cnt;
  logic        fetch_valid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  btb_fetch_pc #(.BTB_ENTRIES(N), .RESET_PC(RP)) dut (
    .i_clk(clk), .i_reset(reset), .i_fetch_allow(fetch_allow),
    .o_fetch_pc(fetch_pc), .o_fetch_valid(fetch_valid), .o_pred_pc(pred_pc),
    .i_resolve_valid(resolve_valid), .i_resolve_is_branch(resolve_is_branch),
    .i_resolve_inst_pc(resolve_inst_pc), .i_resolve_taken(resolve_taken),
    .i_next_pc(next_pc), .i_br_taken_cancel(br_taken_cancel),
    .o_mispred_cnt(mispred_cnt)
  );

  typedef struct {
    bit          rst, allow, rv, rib, tk, cancel;
    logic [31:0] rpc, npc;
    bit          chk;
    logic [31:0] e_pc;
    bit          e_fv;
    logic [31:0] e_pred, e_cnt;
  } vec_t;
  vec_t vt[$];

  // Behavioural model: the table as plain arrays, indices by division/modulo.
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_target[N];
  int          m_ctr   [N];
  logic [31:0] m_pc, m_cnt;
  bit          m_after_cancel;

  function automatic logic [31:0] m_pred(input logic [31:0] pc);
    int unsigned slot = (pc / 4) % N;
    if (m_valid[slot] && m_tag[slot] == pc / (4 * N) && m_ctr[slot] >= 2) return m_target[slot];
    return pc + 32'd4;
  endfunction

  task automatic model_step();
    logic [31:0] p;
    int unsigned slot;
    if (reset) begin
      m_pc = RP; m_cnt = 0; m_after_cancel = 0;
      for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_ctr[i] = 0; end
      return;
    end
    p = m_pred(m_pc);
    if (br_taken_cancel) begin
      m_pc = next_pc; m_after_cancel = 1; m_cnt = m_cnt + 1;
    end else begin
      m_after_cancel = 0;
      if (fetch_allow) m_pc = p;
    end
    if (resolve_valid && resolve_is_branch) begin
      slot = (resolve_inst_pc / 4) % N;
      if (m_valid[slot] && m_tag[slot] == resolve_inst_pc / (4 * N)) begin
        if (resolve_taken) begin
          m_target[slot] = next_pc;
          if (m_ctr[slot] < 3) m_ctr[slot]++;
        end else if (m_ctr[slot] > 0) m_ctr[slot]--;
      end else if (resolve_taken) begin
        m_valid[slot] = 1; m_tag[slot] = resolve_inst_pc / (4 * N);
        m_target[slot] = next_pc; m_ctr[slot] = 2;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input bit rst, allow, rv, rib, tk, cancel, input logic [31:0] rpc, npc,
                     input bit chk, input logic [31:0] e_pc, input bit e_fv,
                     input logic [31:0] e_pred, e_cnt);
    vec_t v;
    v.rst = rst; v.allow = allow; v.rv = rv; v.rib = rib; v.tk = tk; v.cancel = cancel;
    v.rpc = rpc; v.npc = npc; v.chk = chk; v.e_pc = e_pc; v.e_fv = e_fv;
    v.e_pred = e_pred; v.e_cnt = e_cnt;
    vt.push_back(v);
  endtask

  function automatic logic [31:0] pick_pc();
    int r = $urandom_range(0, 9);
    if (r == 0) return 32'hffff_fffc;
    if (r == 1) return 32'h0000_0040;
    return RP + 32'd4 * $urandom_range(0, 47);
  endfunction

  initial begin
    // rst allow rv rib tk cancel rpc npc | chk pc fv pred cnt (outputs seen during the row's cycle)
    add(1,0,0,0,0,0, 0, 0,                       0, 0, 0, 0, 0);
    add(1,0,0,0,0,0, 0, 0,                       1, RP, 0, 32'h1c000004, 0);
    add(0,1,0,0,0,0, 0, 0,                       1, RP, 1, 32'h1c000004, 0);
    add(0,1,0,0,0,0, 0, 0,                       1, 32'h1c000004, 1, 32'h1c000008, 0);
    add(0,0,0,0,0,0, 0, 0,                       1, 32'h1c000008, 1, 32'h1c00000c, 0);
    add(0,0,0,0,0,0, 0, 0,                       1, 32'h1c000008, 1, 32'h1c00000c, 0);
    add(0,0,0,0,0,0, 0, 0,                       1, 32'h1c000008, 1, 32'h1c00000c, 0);
    add(0,1,0,0,0,0, 0, 0,                       1, 32'h1c000008, 1, 32'h1c00000c, 0);
    add(0,1,0,0,0,0, 0, 0,                       1, 32'h1c00000c, 1, 32'h1c000010, 0);
    add(0,1,1,1,1,1, 32'h1c000010, 32'h1c000100, 1, 32'h1c000010, 1, 32'h1c000014, 0);
    add(0,1,0,0,0,0, 0, 0,                       1, 32'h1c000100, 0, 32'h1c000104, 1);
    add(0,0,0,0,0,1, 0, 32'h1c000010,            1, 32'h1c000104, 1, 32'h1c000108, 1);
    add(0,0,0,0,0,0, 0, 0,                       1, 32'h1c000010, 0, 32'h1c000100, 2);
    add(0,0,1,1,0,0, 32'h1c000010, 32'h1c000014, 1, 32'h1c000010, 1, 32'h1c000100, 2);
    add(0,0,0,0,0,0, 0, 0,                       1, 32'h1c000010, 1, 32'h1c000014, 2);
    add(0,0,1,1,1,0, 32'h1c000010, 32'h1c000100, 1, 32'h1c000010, 1, 32'h1c000014, 2);
    add(0,0,0,0,0,1, 0, 32'h1c000050,            1, 32'h1c000010, 1, 32'h1c000100, 2);
    add(0,0,1,1,0,0, 32'h1c000050, 32'h1c000054, 1, 32'h1c000050, 0, 32'h1c000054, 3);
    add(0,0,0,0,0,1, 0, 32'h1c000010,            1, 32'h1c000050, 1, 32'h1c000054, 3);
    add(0,0,0,0,0,0, 0, 0,                       1, 32'h1c000010, 0, 32'h1c000100, 4);
    add(0,0,0,0,0,1, 0, 32'h1c000200,            1, 32'h1c000010, 1, 32'h1c000100, 4);
    add(0,0,0,0,0,0, 0, 0,                       1, 32'h1c000200, 0, 32'h1c000204, 5);
    add(1,1,1,1,1,1, 32'h1c000200, 32'h1c000300, 1, 32'h1c000200, 0, 32'h1c000204, 5);
    add(0,0,0,0,0,1, 0, 32'h1c000010,            1, RP, 1, 32'h1c000004, 0);
    add(0,0,0,0,0,1, 0, 32'h1c000200,            1, 32'h1c000010, 0, 32'h1c000014, 1);
    add(0,0,0,0,0,1, 0, 32'hffff_fffc,           1, 32'h1c000200, 0, 32'h1c000204, 2);
    add(0,1,0,0,0,0, 0, 0,                       1, 32'hffff_fffc, 0, 32'h0000_0000, 3);
    add(0,0,0,0,0,0, 0, 0,                       1, 32'h0000_0000, 1, 32'h0000_0004, 3);

    foreach (vt[k]) begin
      reset = vt[k].rst; fetch_allow = vt[k].allow; resolve_valid = vt[k].rv;
      resolve_is_branch = vt[k].rib; resolve_taken = vt[k].tk; br_taken_cancel = vt[k].cancel;
      resolve_inst_pc = vt[k].rpc; next_pc = vt[k].npc;
      #1;
      if (vt[k].chk) begin
        check($sformatf("vec%0d fetch_pc", k), fetch_pc, vt[k].e_pc);
        check($sformatf("vec%0d fetch_valid", k), {31'd0, fetch_valid}, {31'd0, vt[k].e_fv});
        check($sformatf("vec%0d pred_pc", k), pred_pc, vt[k].e_pred);
        check($sformatf("vec%0d mispred_cnt", k), mispred_cnt, vt[k].e_cnt);
      end
      model_step();
      cyc++;
      @(negedge clk);
    end

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      fetch_allow = ($urandom_range(0, 3) != 0);
      br_taken_cancel = ($urandom_range(0, 4) == 0);
      resolve_valid = $urandom_range(0, 1);
      resolve_is_branch = ($urandom_range(0, 3) != 0);
      resolve_taken = $urandom_range(0, 1);
      resolve_inst_pc = pick_pc();
      next_pc = pick_pc();
      #1;
      check("rnd fetch_pc", fetch_pc, m_pc);
      check("rnd fetch_valid", {31'd0, fetch_valid}, {31'd0, !reset && !m_after_cancel});
      check("rnd pred_pc", pred_pc, m_pred(m_pc));
      check("rnd mispred_cnt", mispred_cnt, m_cnt);
      model_step();
      cyc++;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
